// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, defaults and sizing helpers for mem_access_ctrl
package mem_access_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_PUSH  = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Counter is loaded with (cycles - 1), so it only needs to hold max-1.
    function automatic int cnt_width(input int w, input int r, input int p);
        int m;
        m = clamp1(w);
        if (clamp1(r) > m) m = clamp1(r);
        if (clamp1(p) > m) m = clamp1(p);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_bus_tristate.sv
// rtl/mem_access_ctrl_bus_tristate.sv - tristate driver for the shared memory data bus
module bus_tristate #(
    parameter int DATA_W = 16
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] pad
);

    assign pad = oe ? dout : {DATA_W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer driving the memory d_read/d_write/d_push protocol
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WRITE_CYCLES = 2,
    parameter int READ_CYCLES  = 2,
    parameter int PUSH_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              d_read,
    output logic              d_write,
    output logic              d_push,
    output logic [ADDR_W-1:0] d_addr,
    inout  wire  [DATA_W-1:0] d_bus
);

    localparam int CW = cnt_width(WRITE_CYCLES, READ_CYCLES, PUSH_CYCLES);
    localparam logic [CW-1:0] WC_LOAD = CW'(clamp1(WRITE_CYCLES) - 1);
    localparam logic [CW-1:0] RC_LOAD = CW'(clamp1(READ_CYCLES) - 1);
    localparam logic [CW-1:0] PC_LOAD = CW'(clamp1(PUSH_CYCLES) - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              d_read_q, d_read_d;
    logic              d_write_q, d_write_d;
    logic              d_push_q, d_push_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] bus_in;

    // Strobes are computed for the next state and registered, so each is a clean flop output.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        d_read_d     = d_read_q;
        d_write_d    = d_write_q;
        d_push_d     = d_push_q;
        resp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_we) begin
                        state_d   = ST_WRITE;
                        cnt_d     = WC_LOAD;
                        d_write_d = 1'b1;
                    end else begin
                        state_d  = ST_READ;
                        cnt_d    = RC_LOAD;
                        d_read_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    d_write_d    = 1'b0;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_READ: begin
                if (cnt_q == '0) begin
                    state_d  = ST_PUSH;
                    cnt_d    = PC_LOAD;
                    d_read_d = 1'b0;
                    d_push_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PUSH: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    d_push_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    rdata_d      = bus_in;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                d_read_d  = 1'b0;
                d_write_d = 1'b0;
                d_push_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            d_read_q     <= 1'b0;
            d_write_q    <= 1'b0;
            d_push_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            d_read_q     <= d_read_d;
            d_write_q    <= d_write_d;
            d_push_q     <= d_push_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Output enable is the write strobe flop itself, so the bus is released with d_write.
    bus_tristate #(
        .DATA_W(DATA_W)
    ) u_bus (
        .oe   (d_write_q),
        .dout (wdata_q),
        .din  (bus_in),
        .pad  (d_bus)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign d_read     = d_read_q;
    assign d_write    = d_write_q;
    assign d_push     = d_push_q;
    assign d_addr     = addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  resp_valid;
    logic [15:0] resp_rdata [3];
    logic [2:0]  d_read;
    logic [2:0]  d_write;
    logic [2:0]  d_push;
    logic [15:0] d_addr [3];
    wire  [15:0] bus0;
    wire  [15:0] bus1;
    wire  [15:0] bus2;
    logic [15:0] busv [3];
    logic [15:0] mem [3][16];

    int n_cmp = 0;
    int n_bad = 0;

    // Undriven bus reads back as all ones; no test data uses 16'hFFFF.
    pullup (bus0);
    pullup (bus1);
    pullup (bus2);

    assign bus0 = d_push[0] ? mem[0][d_addr[0][3:0]] : 16'hzzzz;
    assign bus1 = d_push[1] ? mem[1][d_addr[1][3:0]] : 16'hzzzz;
    assign bus2 = d_push[2] ? mem[2][d_addr[2][3:0]] : 16'hzzzz;
    assign busv[0] = bus0;
    assign busv[1] = bus1;
    assign busv[2] = bus2;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (d_write[i]) mem[i][d_addr[i][3:0]] <= busv[i];
    end

    mem_access_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .d_read(d_read[0]), .d_write(d_write[0]), .d_push(d_push[0]),
        .d_addr(d_addr[0]), .d_bus(bus0)
    );

    mem_access_ctrl #(.WRITE_CYCLES(1), .READ_CYCLES(3), .PUSH_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .d_read(d_read[1]), .d_write(d_write[1]), .d_push(d_push[1]),
        .d_addr(d_addr[1]), .d_bus(bus1)
    );

    mem_access_ctrl #(.WRITE_CYCLES(0), .READ_CYCLES(0), .PUSH_CYCLES(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
        .d_read(d_read[2]), .d_write(d_write[2]), .d_push(d_push[2]),
        .d_addr(d_addr[2]), .d_bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request to instance i and watches 12 cycles after the accept edge.
    task automatic run_req(input int i, input logic we, input logic [15:0] a, input logic [15:0] wd,
                           input int exp_w, input int exp_r, input int exp_p, input int exp_lat,
                           input logic [15:0] exp_rd, input string tag);
        int w = 0, r = 0, p = 0, lat = 0, nresp = 0, bad = 0;
        logic [15:0] rd = 16'h0;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_valid[i] = 1'b1;
        check({tag, "_ready"}, {31'd0, req_ready[i]}, 32'd1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        req_we = 1'bx;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (d_write[i]) begin
                w++;
                if (busv[i] !== wd || d_addr[i] !== a) bad++;
            end
            if (d_read[i]) begin
                r++;
                if (busv[i] !== 16'hFFFF || d_addr[i] !== a) bad++;
            end
            if (d_push[i]) begin
                p++;
                if (busv[i] !== mem[i][a[3:0]] || d_addr[i] !== a) bad++;
            end
            if (!d_write[i] && busv[i] !== 16'hFFFF && !d_push[i]) bad++;
            if (int'(d_read[i]) + int'(d_write[i]) + int'(d_push[i]) > 1) bad++;
            if ((c <= exp_lat) == req_ready[i]) bad++;
            if (resp_valid[i]) begin
                nresp++;
                lat = c;
                rd  = resp_rdata[i];
            end
        end
        check({tag, "_wlen"}, w, exp_w);
        check({tag, "_rlen"}, r, exp_r);
        check({tag, "_plen"}, p, exp_p);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_nresp"}, nresp, 1);
        check({tag, "_proto"}, bad, 0);
        check({tag, "_rdata"}, {16'd0, rd}, {16'd0, exp_rd});
    endtask

    initial begin
        int idle_bad, acc, nresp, ovl;
        logic [15:0] last_rd;
        rst_n = 1'b0;
        req_valid = 3'b000;
        req_we = 1'b0;
        req_addr = 16'h0;
        req_wdata = 16'h0;
        #3;
        check("rst_strobes", {26'd0, d_read, d_write}, 32'd0);
        check("rst_push_resp", {26'd0, d_push, resp_valid}, 32'd0);
        check("rst_ready", {29'd0, req_ready}, 32'd7);
        check("rst_addr_rdata", {d_addr[0], resp_rdata[0]}, 32'd0);
        check("rst_bus_z", {bus0, bus1}, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        idle_bad = 0;
        req_we = 1'bx;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((d_read | d_write | d_push | resp_valid) != 3'b000) idle_bad++;
            if (req_ready != 3'b111 || bus0 !== 16'hFFFF || bus2 !== 16'hFFFF) idle_bad++;
        end
        check("idle_20", idle_bad, 0);

        run_req(0, 1'b1, 16'd3, 16'd47, 2, 0, 0, 3, 16'd0, "st3");
        run_req(0, 1'b0, 16'd3, 16'h0, 0, 2, 1, 4, 16'd47, "ld3");

        // Back-to-back: valid held high, store then load of the same address.
        acc = 0; nresp = 0; ovl = 0; last_rd = 16'h0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'h1234;
        for (int c = 0; c < 16; c++) begin
            if (req_valid[0] && req_ready[0]) acc++;
            @(posedge clk);
            #1;
            if (acc == 1) req_we = 1'b0;
            if (acc == 2) req_valid[0] = 1'b0;
            @(negedge clk);
            if (int'(d_read[0]) + int'(d_write[0]) + int'(d_push[0]) > 1) ovl++;
            if (resp_valid[0]) begin
                nresp++;
                last_rd = resp_rdata[0];
            end
        end
        req_valid[0] = 1'b0;
        check("b2b_accepts", acc, 2);
        check("b2b_nresp", nresp, 2);
        check("b2b_overlap", ovl, 0);
        check("b2b_rdata", {16'd0, last_rd}, 32'h1234);

        // Reset in the middle of a load.
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'd3; req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("mid_read_active", {31'd0, d_read[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_read", {31'd0, d_read[0]}, 32'd0);
        check("mid_rst_bus", {16'd0, bus0}, 32'hFFFF);
        check("mid_rst_rdata", {16'd0, resp_rdata[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nresp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid[0]) nresp++;
        end
        check("mid_rst_noresp", nresp, 0);
        run_req(0, 1'b0, 16'd3, 16'h0, 0, 2, 1, 4, 16'd47, "ld3r");

        run_req(1, 1'b1, 16'd7, 16'hBEEF, 1, 0, 0, 2, 16'd0, "s1_st");
        run_req(1, 1'b0, 16'd7, 16'h0, 0, 3, 2, 6, 16'hBEEF, "s1_ld");
        run_req(2, 1'b1, 16'd9, 16'h0A5A, 1, 0, 0, 2, 16'd0, "s0_st");
        run_req(2, 1'b0, 16'd9, 16'h0, 0, 1, 1, 3, 16'h0A5A, "s0_ld");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
